// File: rtl/reg_write_arbiter.sv
// Shares the reg_file write port between writeback and a buffered multicycle unit.
// Optional writeback-stall starvation guard: define REG_ARB_STARVE_GUARD_EN.
module reg_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wb_write,
  input  logic [4:0]               wb_reg_id,
  input  logic [31:0]              wb_val,
  input  logic                     mc_valid,
  input  logic [4:0]               mc_reg_id,
  input  logic [31:0]              mc_val,
  output logic                     mc_ready,
  output logic                     rf_write,
  output logic [4:0]               rf_reg_id,
  output logic [31:0]              rf_val,
  input  logic [4:0]               query_id_1,
  input  logic [4:0]               query_id_2,
  output logic                     pending_1,
  output logic                     pending_2,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     stall_wb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        vld;
    logic [4:0]  id;
    logic [31:0] val;
  } ent_t;

  ent_t [DEPTH-1:0] fifo;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      cnt;
  logic [DEPTH-1:0] squash, hit_1, hit_2;
  logic             empty, wb_req, mc_acc, pop, push, bypass;
  ent_t             head;

  assign fifo_count = cnt;
  assign empty      = (cnt == '0);
  assign head       = fifo[rd_ptr];
  assign mc_ready   = reset_n && (cnt < FULL);
  assign mc_acc     = mc_valid && mc_ready;
  assign wb_req     = wb_write && (wb_reg_id != 5'd0) && !stall_wb;
  assign push       = mc_acc && (mc_reg_id != 5'd0) && !bypass;

  // Per-entry compare: WAW squash against the winning writeback, RAW lookups for decode.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign squash[i] = wb_req && fifo[i].vld && (fifo[i].id == wb_reg_id);
    assign hit_1[i]  = fifo[i].vld && (fifo[i].id == query_id_1);
    assign hit_2[i]  = fifo[i].vld && (fifo[i].id == query_id_2);
  end

  assign pending_1 = (|hit_1) && (query_id_1 != 5'd0);
  assign pending_2 = (|hit_2) && (query_id_2 != 5'd0);

  always_comb begin
    rf_write  = 1'b0;
    rf_reg_id = '0;
    rf_val    = '0;
    pop       = 1'b0;
    bypass    = 1'b0;
    if (reset_n) begin
      if (wb_req) begin
        rf_write  = 1'b1;
        rf_reg_id = wb_reg_id;
        rf_val    = wb_val;
      end else if (!empty) begin
        // A squashed head still retires, just without touching the reg_file.
        pop       = 1'b1;
        rf_write  = head.vld;
        rf_reg_id = head.id;
        rf_val    = head.val;
      end else if (mc_acc && (mc_reg_id != 5'd0)) begin
        bypass    = 1'b1;
        rf_write  = 1'b1;
        rf_reg_id = mc_reg_id;
        rf_val    = mc_val;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fifo   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash[i]) fifo[i].vld <= 1'b0;
      if (pop) begin
        fifo[rd_ptr].vld <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      // Push lands after the squash so a same-edge entry for the same reg survives.
      if (push) begin
        fifo[wr_ptr] <= '{vld: 1'b1, id: mc_reg_id, val: mc_val};
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

`ifdef REG_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      stall_wb   <= 1'b0;
    end else begin
      stall_wb <= 1'b0;
      if (pop || empty) begin
        starve_cnt <= '0;
      end else if (head.vld && wb_req) begin
        if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
          starve_cnt <= '0;
          stall_wb   <= 1'b1;
        end else begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
    end
  end
`else
  wire unused_starve_limit = |STARVE_LIMIT;
  assign stall_wb = 1'b0;
`endif

endmodule
